// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel between the host byte source and the program loader.
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-stage program loader: receives a LEN/data/CSUM byte image, writes it into the
// CPU instruction memory and holds the CPU in reset until the image has been verified.
module program_loader #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BOOT_CYCLES    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  program_loader_if.slave src,
  output logic            ins_write,
  output logic            ins_read,
  output logic [7:0]      instruction_write_data,
  output logic            wr_strobe,
  output logic [7:0]      load_addr,
  output logic            cpu_reset,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BOOT_CYCLES + 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
  localparam logic [1:0] ERR_CSUM     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_BOOT, S_RUN, S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      err_set;
  logic            in_ready_q;
  logic [7:0]      len_q, cnt_q, sum_q, sum_plus;
  logic [TW-1:0]   idle_cnt;
  logic [BW-1:0]   boot_cnt;
  logic            xfer, loading, loading_nxt, timed_out, boot_last;

  assign xfer        = src.in_valid && in_ready_q;
  assign sum_plus    = sum_q + src.in_data;
  assign loading     = state inside {S_LEN, S_DATA, S_CSUM};
  assign loading_nxt = state_nxt inside {S_LEN, S_DATA, S_CSUM};
  // An accepted byte on the limit cycle wins over the timeout.
  assign timed_out   = loading && !xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign boot_last   = (boot_cnt == BW'(BOOT_CYCLES - 1));

  assign src.in_ready = in_ready_q;
  assign ins_read     = ~ins_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b0;
      ins_write  <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= loading_nxt;
      ins_write  <= loading_nxt;
      cpu_reset  <= (state_nxt != S_RUN);
      done       <= (state_nxt == S_RUN);
      error      <= (state_nxt == S_ERROR);
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = ERR_NONE;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_LEN;
      S_LEN: begin
        if (xfer) begin
          if (src.in_data == 8'h00) begin
            state_nxt = S_ERROR;
            err_set   = ERR_ZERO_LEN;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: if (xfer && (cnt_q == len_q - 8'd1)) state_nxt = S_CSUM;
      S_CSUM: begin
        if (xfer) begin
          if (sum_plus == 8'h00) begin
            state_nxt = S_BOOT;
          end else begin
            state_nxt = S_ERROR;
            err_set   = ERR_CSUM;
          end
        end
      end
      S_BOOT:  if (boot_last) state_nxt = S_RUN;
      S_RUN:   if (start) state_nxt = S_LEN;
      S_ERROR: if (start) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
    if (timed_out) begin
      state_nxt = S_ERROR;
      err_set   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_write_data <= 8'h00;
      wr_strobe              <= 1'b0;
      load_addr              <= 8'h00;
      len_q                  <= 8'h00;
      cnt_q                  <= 8'h00;
      sum_q                  <= 8'h00;
      idle_cnt               <= '0;
      boot_cnt               <= '0;
      err_code               <= ERR_NONE;
    end else begin
      wr_strobe <= 1'b0;
      idle_cnt  <= (!loading || xfer) ? '0 : idle_cnt + 1'b1;
      boot_cnt  <= (state == S_BOOT) ? boot_cnt + 1'b1 : '0;

      if (xfer && state == S_LEN) begin
        len_q     <= src.in_data;
        sum_q     <= src.in_data;
        cnt_q     <= 8'h00;
        load_addr <= 8'h00;
      end

      // Each byte is presented with its own index, so the address stops on the last byte.
      if (xfer && state == S_DATA) begin
        instruction_write_data <= src.in_data;
        wr_strobe              <= 1'b1;
        load_addr              <= cnt_q;
        cnt_q                  <= cnt_q + 8'd1;
        sum_q                  <= sum_plus;
      end

      if (err_set != ERR_NONE) begin
        err_code <= err_set;
      end else if (state_nxt == S_LEN) begin
        err_code <= ERR_NONE;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: fixed and randomized images checked against a length/checksum
// reference model, plus reset, timeout, stall-gap, maximum-length and reload scenarios.
module tb_program_loader;
  localparam int TIMEOUT = 1024;
  localparam int BOOT    = 4;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       ins_write, ins_read, wr_strobe, cpu_reset, done, error;
  logic [7:0] instruction_write_data, load_addr;
  logic [1:0] err_code;

  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  bit  stuck = 1'b0;
  wr_t wq[$];

  program_loader_if bus();

  program_loader #(.TIMEOUT_CYCLES(TIMEOUT), .BOOT_CYCLES(BOOT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .src                    (bus),
    .ins_write              (ins_write),
    .ins_read               (ins_read),
    .instruction_write_data (instruction_write_data),
    .wr_strobe              (wr_strobe),
    .load_addr              (load_addr),
    .cpu_reset              (cpu_reset),
    .done                   (done),
    .error                  (error),
    .err_code               (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Every write the CPU would see: (address, byte, cycle of the strobe)
  always @(negedge clk) begin
    if (reset && wr_strobe) begin
      wr_t w;
      w.a = load_addr;
      w.d = instruction_write_data;
      w.c = cyc;
      wq.push_back(w);
    end
  end

  // Reference outcome of an image: 00 boots, 01 zero length, 10 bad checksum.
  function automatic logic [1:0] model_code(input byte_q_t img);
    int s = 0;
    if (img[0] == 8'd0) return 2'b01;
    foreach (img[i]) s += int'(img[i]);
    return (s % 256 == 0) ? 2'b00 : 2'b10;
  endfunction

  function automatic byte_q_t seal(input byte_q_t q, input bit corrupt);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    q.push_back(8'((256 - s % 256) % 256 + int'(corrupt)));
    return q;
  endfunction

  function automatic byte_q_t make_image(input int len, input bit corrupt);
    byte_q_t q;
    q.push_back(8'(len));
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return seal(q, corrupt);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (stuck) return;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL accept_wait: in_ready got %b, required 1 within 50 cycles", bus.in_ready);
      stuck = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic run_image(input string tag, input byte_q_t img, input int gap_lo,
                           input int gap_hi, input int poke_at);
    logic [1:0] exp_code;
    int nsend, nwr;
    exp_code = model_code(img);
    nsend    = (img[0] == 8'd0) ? 1 : img.size();
    nwr      = int'(img[0]);
    stuck    = 1'b0;
    pulse_start();
    wq.delete();
    compared++;
    if (bus.in_ready !== 1'b1 || cpu_reset !== 1'b1 || error !== 1'b0 ||
        err_code !== 2'b00 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s start: ready/cpu_reset/error/err_code/done got %b %b %b %b %b, required 1 1 0 00 0",
               tag, bus.in_ready, cpu_reset, error, err_code, done);
    end
    for (int i = 0; i < nsend; i++) begin
      if (i == poke_at) pulse_start();
      send_byte(img[i], int'($urandom_range(gap_hi, gap_lo)));
    end
    if (exp_code == 2'b00) begin
      for (int k = 0; k < BOOT; k++) begin
        @(negedge clk);
        compared++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
          mismatched++;
          $display("FAIL %s boot_hold[%0d]: cpu_reset=%b done=%b, required 1 0", tag, k, cpu_reset, done);
        end
      end
      @(negedge clk);
      compared++;
      if (cpu_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0 || err_code !== 2'b00) begin
        mismatched++;
        $display("FAIL %s run: cpu_reset=%b done=%b error=%b err_code=%b, required 0 1 0 00",
                 tag, cpu_reset, done, error, err_code);
      end
    end else begin
      @(negedge clk);
      compared++;
      if (error !== 1'b1 || err_code !== exp_code || bus.in_ready !== 1'b0 ||
          cpu_reset !== 1'b1 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL %s error: error=%b err_code=%b ready=%b cpu_reset=%b done=%b, required 1 %b 0 1 0",
                 tag, error, err_code, bus.in_ready, cpu_reset, done, exp_code);
      end
    end
    compared++;
    if (wq.size() != nwr) begin
      mismatched++;
      $display("FAIL %s write_count: got %0d, required %0d", tag, wq.size(), nwr);
    end else begin
      for (int i = 0; i < nwr; i++) begin
        compared++;
        if (wq[i].a !== 8'(i) || wq[i].d !== img[i+1]) begin
          mismatched++;
          $display("FAIL %s write[%0d]: got %h@%h, required %h@%h", tag, i, wq[i].d, wq[i].a, img[i+1], 8'(i));
        end
        if (gap_hi == 0 && poke_at < 0 && i > 0) begin
          compared++;
          if (wq[i].c - wq[i-1].c != 1) begin
            mismatched++;
            $display("FAIL %s throughput[%0d]: strobe spacing %0d, required 1", tag, i, wq[i].c - wq[i-1].c);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        stuck = 1'b0;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        @(negedge clk);
        reset = 1'b0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      wq.delete();
      compared++;
      if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready[%0d]: got %b, required 0", pass, bus.in_ready); end
      compared++;
      if (ins_write !== 1'b0 || ins_read !== 1'b1) begin mismatched++; $display("FAIL reset_ins[%0d]: write=%b read=%b, required 0 1", pass, ins_write, ins_read); end
      compared++;
      if (instruction_write_data !== 8'h00) begin mismatched++; $display("FAIL reset_data[%0d]: got %h, required 00", pass, instruction_write_data); end
      compared++;
      if (wr_strobe !== 1'b0) begin mismatched++; $display("FAIL reset_strobe[%0d]: got %b, required 0", pass, wr_strobe); end
      compared++;
      if (load_addr !== 8'h00) begin mismatched++; $display("FAIL reset_addr[%0d]: got %h, required 00", pass, load_addr); end
      compared++;
      if (cpu_reset !== 1'b1) begin mismatched++; $display("FAIL reset_cpu_reset[%0d]: got %b, required 1", pass, cpu_reset); end
      compared++;
      if (done !== 1'b0 || error !== 1'b0 || err_code !== 2'b00) begin
        mismatched++;
        $display("FAIL reset_status[%0d]: done=%b error=%b err_code=%b, required 0 0 00", pass, done, error, err_code);
      end
    end
    // Without a fresh start the loader must ignore an offered byte.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    compared++;
    if (bus.in_ready !== 1'b0 || ins_write !== 1'b0 || wq.size() != 0) begin
      mismatched++;
      $display("FAIL reset_idle: ready=%b ins_write=%b writes=%0d, required 0 0 0", bus.in_ready, ins_write, wq.size());
    end
  endtask

  task automatic test_good_image();
    byte_q_t img;
    img.push_back(8'h03);
    img.push_back(8'hA1);
    img.push_back(8'hB2);
    img.push_back(8'hC3);
    run_image("good_image", seal(img, 1'b0), 0, 0, -1);
  endtask

  task automatic test_bad_checksum();
    byte_q_t img;
    img.push_back(8'h02);
    img.push_back(8'h10);
    img.push_back(8'h20);
    img.push_back(8'h00);
    run_image("bad_checksum", img, 0, 0, -1);
  endtask

  task automatic test_zero_length();
    byte_q_t img;
    img.push_back(8'h00);
    run_image("zero_length", img, 0, 0, -1);
  endtask

  task automatic test_timeout();
    stuck = 1'b0;
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("FAIL timeout_early: error got %b, required 0", error); end
    @(negedge clk);
    compared++;
    if (error !== 1'b1 || err_code !== 2'b11 || bus.in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout: error=%b err_code=%b ready=%b cpu_reset=%b, required 1 11 0 1",
               error, err_code, bus.in_ready, cpu_reset);
    end
    run_image("after_timeout", make_image(int'($urandom_range(8, 1)), 1'b0), 0, 2, -1);
  endtask

  task automatic test_stall_gaps();
    run_image("stall_gaps", make_image(3, 1'b0), TIMEOUT - 1, TIMEOUT - 1, -1);
  endtask

  task automatic test_max_length_reload();
    run_image("max_length", make_image(255, 1'b0), 0, 0, -1);
    compared++;
    if (wq.size() == 0 || wq[wq.size()-1].a !== 8'hFE) begin
      mismatched++;
      $display("FAIL max_length_last_addr: got %h, required fe", (wq.size() == 0) ? 8'h00 : wq[wq.size()-1].a);
    end
    run_image("reload", make_image(int'($urandom_range(20, 1)), 1'b0), 0, 1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int  len;
      bit  bad;
      len = int'($urandom_range(16, 0));
      bad = ($urandom_range(3, 0) == 0);
      run_image($sformatf("random%0d", n), make_image(len, bad), 0, int'($urandom_range(3, 0)),
                (len >= 2 && $urandom_range(1, 0) == 1) ? 2 : -1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_zero_length();
    test_timeout();
    test_stall_gaps();
    test_max_length_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
